// File: rtl/fpu_round_pkg.sv
// Shared FPU rounding constants: rounding-mode encodings and round-flag payload.
package fpu_round_pkg;

  localparam int unsigned RM_W      = 2;
  localparam int unsigned EXP_ADJ_W = 2;

  // Rounding modes shared by the multiplier and adder normalization paths.
  typedef enum logic [RM_W-1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  // Bits shifted out below the kept significand.
  typedef struct packed {
    logic guard;
    logic sticky;
  } round_flags_t;

endpackage

// File: rtl/round_incr.sv
// Round decision and increment of a SIG_W-bit significand; combinational.
module round_incr
  import fpu_round_pkg::*;
#(
  parameter int unsigned SIG_W = 53
) (
  input  logic [SIG_W-1:0] mant,
  input  round_flags_t     rf,
  input  logic             sign,
  input  rmode_e           rmode,
  output logic [SIG_W:0]   sum_c
);

  logic inc;

  // Increment decision per rounding mode, then the carry-extended sum.
  always_comb begin
    inc = 1'b0;
    unique case (rmode)
      RM_RNE: inc = rf.guard & (rf.sticky | mant[0]);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = ~sign & (rf.guard | rf.sticky);
      RM_RDN: inc = sign & (rf.guard | rf.sticky);
      default: inc = 1'b0;
    endcase
    sum_c = {1'b0, mant} + (SIG_W+1)'(inc);
  end

endmodule

// File: rtl/sgf_norm_round.sv
// Two-stage significand normalize (S1) and round (S2) after the multiplier.
module sgf_norm_round
  import fpu_round_pkg::*;
#(
  parameter int unsigned SW    = 54,
  parameter int unsigned SIG_W = 53
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*SW-1:0]      product_i,
  input  logic                 sign_i,
  input  logic [RM_W-1:0]      rmode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [SIG_W-1:0]     sgf_o,
  output logic [EXP_ADJ_W-1:0] exp_adj_o,
  output logic                 inexact_o
);

  localparam int unsigned PW = 2 * SIG_W;

  logic [PW-1:0]    prod;
  logic             n_c;
  logic [SIG_W-1:0] mant_c;
  round_flags_t     rf_c;

  logic             v1;
  logic             n1;
  logic [SIG_W-1:0] mant1;
  round_flags_t     rf1;
  logic             sign1;
  rmode_e           rmode1;

  logic             v2;
  logic             ready2;
  logic [SIG_W:0]   sum_c;
  logic [SIG_W-1:0] sgf_c;
  logic [EXP_ADJ_W-1:0] exp_adj_c;

  assign prod = product_i[PW-1:0];

  // Upper product bits are zero by contract when SW > SIG_W.
  if (SW > SIG_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |product_i[2*SW-1:PW];
  end

  // Elastic handshake: each stage frees up when empty or when its successor moves.
  assign ready2  = ~v2 | ready_i;
  assign ready_o = ~v1 | ready2;
  assign valid_o = v2;

  // Normalize: pick the kept window by the product MSB and collect round bits.
  always_comb begin
    n_c       = prod[PW-1];
    mant_c    = prod[PW-2:SIG_W-1];
    rf_c      = '0;
    rf_c.guard  = prod[SIG_W-2];
    rf_c.sticky = |prod[SIG_W-3:0];
    if (n_c) begin
      mant_c      = prod[PW-1:SIG_W];
      rf_c.guard  = prod[SIG_W-1];
      rf_c.sticky = |prod[SIG_W-2:0];
    end
  end

  // S1 register: loads on accept, holds while S2 is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 1'b0;
      n1     <= 1'b0;
      mant1  <= '0;
      rf1    <= '0;
      sign1  <= 1'b0;
      rmode1 <= RM_RNE;
    end else if (ready_o) begin
      v1 <= valid_i;
      if (valid_i) begin
        n1     <= n_c;
        mant1  <= mant_c;
        rf1    <= rf_c;
        sign1  <= sign_i;
        rmode1 <= rmode_e'(rmode_i);
      end
    end
  end

  round_incr #(
    .SIG_W (SIG_W)
  ) u_round_incr (
    .mant  (mant1),
    .rf    (rf1),
    .sign  (sign1),
    .rmode (rmode1),
    .sum_c (sum_c)
  );

  // Rounding carry renormalizes to 1.000... and bumps the exponent once more.
  always_comb begin
    sgf_c     = sum_c[SIG_W-1:0];
    exp_adj_c = EXP_ADJ_W'(n1);
    if (sum_c[SIG_W]) begin
      sgf_c     = {1'b1, {(SIG_W-1){1'b0}}};
      exp_adj_c = EXP_ADJ_W'(n1) + EXP_ADJ_W'(1);
    end
  end

  // S2 register: output stage, holds stable while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2        <= 1'b0;
      sgf_o     <= '0;
      exp_adj_o <= '0;
      inexact_o <= 1'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        sgf_o     <= sgf_c;
        exp_adj_o <= exp_adj_c;
        inexact_o <= rf1.guard | rf1.sticky;
      end
    end
  end

endmodule

// File: tb/tb_sgf_norm_round.sv
// Self-checking bench for sgf_norm_round at single precision (SW = SIG_W = 24).
module tb_sgf_norm_round;
  import fpu_round_pkg::*;

  localparam int unsigned S  = 24;
  localparam int unsigned PW = 2 * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [PW-1:0] product_i;
  logic          sign_i;
  logic [1:0]    rmode_i;
  logic          valid_o;
  logic          ready_i;
  logic [S-1:0]  sgf_o;
  logic [1:0]    exp_adj_o;
  logic          inexact_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sgf_norm_round #(.SW(S), .SIG_W(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .product_i (product_i),
    .sign_i    (sign_i),
    .rmode_i   (rmode_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sgf_o     (sgf_o),
    .exp_adj_o (exp_adj_o),
    .inexact_o (inexact_o)
  );

  typedef struct packed {
    logic [S-1:0] sgf;
    logic [1:0]   adj;
    logic         inx;
  } res_t;

  typedef struct {
    logic [PW-1:0] p;
    logic          s;
    logic [1:0]    rm;
    res_t          exp;
  } vec_t;

  vec_t tv[$];
  res_t exp_q[$];
  bit   sb_on = 0;
  int   n_pop = 0;
  int   n_push = 0;
  bit   prev_stall = 0;
  res_t prev_out;
  res_t sb_r;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: value arithmetic on the product (remainder vs. half-ulp).
  function automatic res_t model(input logic [PW-1:0] p, input logic s, input logic [1:0] rm);
    longint unsigned pv, mant, rem, half, r;
    int  sh;
    int  n;
    bit  up;
    res_t o;
    pv   = 64'(p);
    n    = (pv >= (64'd1 << (PW-1))) ? 1 : 0;
    sh   = S - 1 + n;
    mant = pv >> sh;
    rem  = pv - (mant << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && (mant % 2 == 1));
      2'd1:    up = 0;
      2'd2:    up = !s && (rem != 0);
      default: up = s && (rem != 0);
    endcase
    r = mant + (up ? 64'd1 : 64'd0);
    if (r == (64'd1 << S)) begin
      o.sgf = {1'b1, {(S-1){1'b0}}};
      o.adj = 2'(n + 1);
    end else begin
      o.sgf = S'(r);
      o.adj = 2'(n);
    end
    o.inx = (rem != 0);
    return o;
  endfunction

  function automatic logic [PW-1:0] rand_prod();
    logic [S-1:0]  a, b;
    logic [PW-1:0] p;
    a = {1'b1, (S-1)'($urandom)};
    b = {1'b1, (S-1)'($urandom)};
    p = PW'(a) * PW'(b);
    case ($urandom_range(0, 7))
      0: p = '0;
      1: if (p[PW-1]) p[S-1:0] = {1'b1, {(S-1){1'b0}}};
         else         p[S-2:0] = {1'b1, {(S-2){1'b0}}};
      2: p[PW-1:S] = '1;
      default: ;
    endcase
    return p;
  endfunction

  task automatic add_vec(input logic [PW-1:0] p, input logic s, input logic [1:0] rm,
                         input logic [S-1:0] sgf, input logic [1:0] adj, input logic inx);
    vec_t v;
    v.p = p; v.s = s; v.rm = rm;
    v.exp.sgf = sgf; v.exp.adj = adj; v.exp.inx = inx;
    tv.push_back(v);
  endtask

  // Scoreboard: predict on accept, compare on emit, and check hold during stalls.
  always @(negedge clk) begin
    if (sb_on) begin
      if (prev_stall) begin
        check("stall_valid", 64'(valid_o), 64'(1));
        check("stall_data", 64'({sgf_o, exp_adj_o, inexact_o}), 64'(prev_out));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got output 0x%0h, expected none", {sgf_o, exp_adj_o, inexact_o});
        end else begin
          sb_r = exp_q.pop_front();
          check("sb_result", 64'({sgf_o, exp_adj_o, inexact_o}), 64'(sb_r));
          n_pop++;
        end
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(product_i, sign_i, rmode_i));
        n_push++;
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = {sgf_o, exp_adj_o, inexact_o};
    end else begin
      prev_stall = 0;
    end
  end

  logic [PW-1:0] bp[5];
  int k;
  int n0;

  initial begin
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    product_i = '0; sign_i = 1'b0; rmode_i = 2'b00;

    add_vec(48'h400000000000, 0, 2'd0, 24'h800000, 2'd0, 0);
    add_vec(48'h900000000000, 0, 2'd0, 24'h900000, 2'd1, 0);
    add_vec(48'h400000400000, 0, 2'd0, 24'h800000, 2'd0, 1);
    add_vec(48'h400000C00000, 0, 2'd0, 24'h800002, 2'd0, 1);
    add_vec(48'hFFFFFF800000, 0, 2'd0, 24'h800000, 2'd2, 1);
    add_vec(48'hFFFFFF800000, 0, 2'd1, 24'hFFFFFF, 2'd1, 1);
    add_vec(48'hFFFFFE000001, 0, 2'd2, 24'hFFFFFF, 2'd1, 1);
    add_vec(48'hFFFFFE000001, 1, 2'd2, 24'hFFFFFE, 2'd1, 1);
    add_vec(48'hFFFFFE000001, 1, 2'd3, 24'hFFFFFF, 2'd1, 1);
    add_vec(48'hFFFFFE000001, 0, 2'd3, 24'hFFFFFE, 2'd1, 1);
    add_vec(48'hFFFFFE000001, 0, 2'd0, 24'hFFFFFE, 2'd1, 1);
    add_vec(48'h000000000000, 0, 2'd2, 24'h000000, 2'd0, 0);
    add_vec(48'h000000000000, 1, 2'd3, 24'h000000, 2'd0, 0);
    add_vec(48'hFFFFFF800000, 0, 2'd2, 24'h800000, 2'd2, 1);
    add_vec(48'h400000000001, 1, 2'd3, 24'h800001, 2'd0, 1);

    // Reset state
    #12;
    check("rst_valid_o", 64'(valid_o), 64'(0));
    check("rst_ready_o", 64'(ready_o), 64'(1));
    check("rst_sgf_o", 64'(sgf_o), 64'(0));
    check("rst_exp_adj_o", 64'(exp_adj_o), 64'(0));
    check("rst_inexact_o", 64'(inexact_o), 64'(0));
    @(negedge clk); rst = 1'b1;

    // Table vectors, one at a time, with latency check
    foreach (tv[i]) begin
      @(posedge clk); #1;
      valid_i = 1'b1; product_i = tv[i].p; sign_i = tv[i].s; rmode_i = tv[i].rm;
      @(negedge clk);
      check($sformatf("tv%0d_ready", i), 64'(ready_o), 64'(1));
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      check($sformatf("tv%0d_early", i), 64'(valid_o), 64'(0));
      @(posedge clk); @(negedge clk);
      check($sformatf("tv%0d_valid", i), 64'(valid_o), 64'(1));
      check($sformatf("tv%0d_result", i), 64'({sgf_o, exp_adj_o, inexact_o}), 64'(tv[i].exp));
    end

    // Back-pressure: 5 back-to-back items, downstream stalled for 3 cycles
    bp[0] = 48'h400000000000; bp[1] = 48'h900000000000; bp[2] = 48'hFFFFFF800000;
    bp[3] = 48'h400000C00000; bp[4] = 48'hA5A5A5000001;
    @(posedge clk); #1;
    sb_on = 1; n0 = n_pop; k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(posedge clk); #1;
      ready_i = (c >= 3);
      valid_i = 1'b1; product_i = bp[k]; sign_i = 1'b0; rmode_i = 2'd0;
      @(negedge clk);
      if (c == 2) check("bp_ready_low", 64'(ready_o), 64'(0));
      if (ready_o) k++;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("bp_count", 64'(n_pop - n0), 64'(5));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      valid_i   = ($urandom_range(0, 9) < 7);
      ready_i   = ($urandom_range(0, 9) < 6);
      product_i = rand_prod();
      sign_i    = 1'($urandom);
      rmode_i   = 2'($urandom);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rnd_drained", 64'(exp_q.size()), 64'(0));
    check("rnd_count", 64'(n_pop), 64'(n_push));

    // Reset with two items in flight
    @(posedge clk); #1;
    sb_on = 0; exp_q.delete();
    valid_i = 1'b1; product_i = 48'h900000000000; sign_i = 1'b0; rmode_i = 2'd0;
    @(posedge clk); #1;
    product_i = 48'hFFFFFF800000;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("rst_pre_valid", 64'(valid_o), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", 64'(valid_o), 64'(0));
    check("rst_async_ready", 64'(ready_o), 64'(1));
    check("rst_async_data", 64'({sgf_o, exp_adj_o, inexact_o}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(valid_o), 64'(0));
    end
    @(posedge clk); #1;
    valid_i = 1'b1; product_i = 48'h400000C00000; sign_i = 1'b0; rmode_i = 2'd0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_early", 64'(valid_o), 64'(0));
    @(posedge clk); @(negedge clk);
    check("post_rst_valid", 64'(valid_o), 64'(1));
    check("post_rst_result", 64'({sgf_o, exp_adj_o, inexact_o}), 64'({24'h800002, 2'd0, 1'b1}));
    @(posedge clk); @(negedge clk);
    check("post_rst_single", 64'(valid_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sgf_norm_round.md
SGF_NORM_ROUND -- requirements
Module: sgf_norm_round

Interface
REQ-001 SHALL have parameter SW, default 54: width of each multiplier operand; the product input is 2*SW bits.
REQ-002 SHALL have parameter SIG_W, default 53: output significand width including the hidden bit. SIG_W SHALL be <= SW; 24/24 for single precision.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1 bit: product_i, sign_i and rmode_i are valid.
REQ-006 SHALL have port ready_o, output, 1 bit: the stage accepts the input this cycle.
REQ-007 SHALL have port product_i, input, 2*SW bits: significand product from the upstream Karatsuba multiplier; bits above 2*SIG_W-1 are zero.
REQ-008 SHALL have port sign_i, input, 1 bit: result sign, used for directed rounding.
REQ-009 SHALL have port rmode_i, input, 2 bits: rounding mode; 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-010 SHALL have port valid_o, output, 1 bit: outputs are valid.
REQ-011 SHALL have port ready_i, input, 1 bit: the downstream stage accepts.
REQ-012 SHALL have port sgf_o, output, SIG_W bits: normalized, rounded significand with MSB = 1 unless the product is zero.
REQ-013 SHALL have port exp_adj_o, output, 2 bits: exponent increment to apply downstream, in the range 0..2.
REQ-014 SHALL have port inexact_o, output, 1 bit: guard | sticky.

Function
REQ-015 SHALL be a 2-stage pipeline. S1 registers the normalized fields; S2 registers the rounded result. Latency is 2 cycles with no stalls; throughput is 1 per cycle.
REQ-016 S1 normalization SHALL work on P = product_i[2*SIG_W-1:0].
  - n = P[2*SIG_W-1].
  - If n = 1: mant = P[2*SIG_W-1:SIG_W], guard = P[SIG_W-1], sticky = OR(P[SIG_W-2:0]).
  - If n = 0: mant = P[2*SIG_W-2:SIG_W-1], guard = P[SIG_W-2], sticky = OR(P[SIG_W-3:0]).
REQ-017 S2 SHALL compute the round increment inc as follows:
  - RNE: guard & (sticky | mant[0]).
  - RTZ: 0.
  - RUP: ~sign & (guard | sticky).
  - RDN: sign & (guard | sticky).
REQ-018 S2 SHALL compute the SIG_W+1-bit sum = mant + inc.
  - On carry-out: sgf_o = {1'b1, zeros}, exp_adj_o = n + 1.
  - Otherwise: sgf_o = sum[SIG_W-1:0], exp_adj_o = n.
REQ-019 A product of all zeros SHALL give sgf_o = 0, exp_adj_o = 0, inexact_o = 0.
REQ-020 Handshake SHALL use ready2 = ~v2 | ready_i and ready_o = ~v1 | ready2. Per-stage valids are v1 and v2; valid_o = v2.
  - Transfer occurs when valid and ready are both high.
  - When a stage stalls, its registers SHALL hold.
  - ready_o SHALL NOT depend on valid_i.
REQ-021 When S2 output is full and ready_i = 0, valid_o and all data outputs SHALL remain stable until ready_i = 1.
REQ-022 Simultaneous accept and emit with both stages full and ready_i = 1 SHALL advance both stages in the same cycle with no bubble.
REQ-023 Data registers SHALL NOT load when valid_i = 0 at an accept; v1 SHALL clear in that case.

Reset
REQ-024 While rst = 0:
  - v1, v2 and valid_o SHALL be 0 immediately.
  - sgf_o, exp_adj_o and inexact_o SHALL be 0.
  - ready_o SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight items. The first accept after release SHALL appear at valid_o 2 cycles later.

Structure
REQ-026 Rounding-mode encodings (RM_RNE, RM_RTZ, RM_RUP, RM_RDN) SHALL live in the shared FPU constants package fpu_round_pkg, used by both the multiplier and adder paths.
REQ-027 The S2 round decision and increment SHALL be one sub-module, round_incr. It is combinational, parameterized by SIG_W, and reusable by the FP adder normalizer.
REQ-028 Total RTL SHALL be between 120 and 400 lines.

Verification (SW = SIG_W = 24)
REQ-029 Basic products (RNE, ready_i = 1):
  - product_i = 0x400000000000 (1.0×1.0) -> sgf_o = 0x800000, exp_adj_o = 0, inexact_o = 0, 2 cycles after accept.
  - product_i = 0x900000000000 (1.5×1.5) -> sgf_o = 0x900000, exp_adj_o = 1.
REQ-030 RNE ties:
  - product_i = 0x400000400000 -> sgf_o = 0x800000 (tie, even LSB kept), inexact_o = 1.
  - product_i = 0x400000C00000 -> sgf_o = 0x800002.
REQ-031 Rounding carry:
  - product_i = 0xFFFFFF800000, RNE -> sgf_o = 0x800000, exp_adj_o = 2, inexact_o = 1.
  - Same product, RTZ -> sgf_o = 0xFFFFFF, exp_adj_o = 1.
REQ-032 Directed modes, product_i = 0xFFFFFE000001:
  - RUP, sign_i = 0 -> 0xFFFFFF.
  - RUP, sign_i = 1 -> 0xFFFFFE.
  - RDN, sign_i = 1 -> 0xFFFFFF.
REQ-033 Back-pressure: stream 5 items back-to-back while ready_i = 0 for 3 cycles.
  - ready_o falls after 2 items are held.
  - Outputs stay stable while stalled.
  - All 5 results emerge in order with no loss or duplication.
REQ-034 Reset mid-operation: pull rst low with 2 items in flight.
  - valid_o drops asynchronously.
  - After release, a new item emerges 2 cycles after accept and no stale item appears.
